// File: rtl/branch_address_stack.sv
// branch_address_stack: circular LIFO of branch addresses; BRANCH_STACK_OVERFLOW_WRAP_EN lets a push while full overwrite the oldest entry
module branch_address_stack #(
  parameter int NrOfBits = 16,
  parameter int Depth = 8,
  parameter int ActiveLevel = 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         ClockEnable,
  input  logic                         Tick,
  input  logic                         pre,
  input  logic                         Push,
  input  logic                         Pop,
  input  logic [NrOfBits-1:0]          D,
  input  logic                         ClearErr,
  input  logic                         cs,
  output logic [NrOfBits-1:0]          Q,
  output logic [$clog2(Depth+1)-1:0]   Count,
  output logic                         Empty,
  output logic                         Full,
  output logic                         Overflow,
  output logic                         Underflow
);
  localparam int SW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);
  logic [NrOfBits-1:0] mem [Depth];
  logic [SW-1:0] sp, sp_inc, top;
  logic clk_a, step, wr, rep, pop_op, inc, ovf_set, unf_set;
  assign clk_a = (ActiveLevel != 0) ? Clock : ~Clock;
  assign Empty = Count == '0;
  assign Full = Count == CW'(Depth);
  assign sp_inc = (sp == SW'(Depth-1)) ? '0 : sp + SW'(1);
  assign top = (sp == '0) ? SW'(Depth-1) : sp - SW'(1);
  assign step = ClockEnable & Tick;
  assign ovf_set = Push & ~Pop & Full;
  assign unf_set = Pop & ~Push & Empty;
  assign rep = Push & Pop & ~Empty;
  assign pop_op = Pop & ~Push & ~Empty;
  assign inc = Push & (~Pop | Empty) & ~Full;
`ifdef BRANCH_STACK_OVERFLOW_WRAP_EN
  assign wr = inc | ovf_set;
`else
  assign wr = inc;
`endif
  assign Q = cs ? {NrOfBits{1'bz}} : (Empty ? '0 : mem[top]);
  // Entry storage: async clear, async preset to all-ones, then push or top replace
  always_ff @(posedge clk_a or posedge Reset or posedge pre)
    if (Reset)
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    else if (pre)
      for (int i = 0; i < Depth; i++) mem[i] <= '1;
    else if (step & wr)
      mem[sp] <= D;
    else if (step & rep)
      mem[top] <= D;
  // Pointer, occupancy and sticky flags; a held preset freezes them
  always_ff @(posedge clk_a or posedge Reset)
    if (Reset) begin
      sp <= '0;
      Count <= '0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else if (step & ~pre) begin
      sp <= wr ? sp_inc : pop_op ? top : sp;
      Count <= inc ? Count + CW'(1) : pop_op ? Count - CW'(1) : Count;
      Overflow <= ovf_set | (Overflow & ~ClearErr);
      Underflow <= unf_set | (Underflow & ~ClearErr);
    end
endmodule
